// File: rtl/int_sched_pkg.sv
// Shared constants for the Nandy interrupt scheduler.
// State encoding, vector defaults and the id-width helper.
package int_pkg;

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_ENTER   = 2'd1;
    localparam logic [1:0] ST_SERVICE = 2'd2;

    localparam logic [15:0] VEC_BASE_DEF  = 16'hFF00;
    localparam int          VEC_SHIFT_DEF = 2;

    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/int_sched_if.sv
// Core/regfile-side bundle of the interrupt scheduler.
// The slave modport is the scheduler's view.
interface int_sched_if #(
    parameter int NIRQ = 4
);
    import int_pkg::*;

    localparam int IDW = id_w(NIRQ);

    logic [NIRQ-1:0] irq;
    logic [15:0]     pc;
    logic            ibound;
    logic            ei;
    logic            di;
    logic            rti;
    logic            mask_wr;
    logic [NIRQ-1:0] mask_in;

    logic            ienabled;
    logic            istatus;
    logic [15:0]     intRA;
    logic            take;
    logic [15:0]     vector;
    logic [IDW-1:0]  active_id;
    logic [NIRQ-1:0] pending;

    modport master (
        output irq, pc, ibound, ei, di, rti, mask_wr, mask_in,
        input  ienabled, istatus, intRA, take, vector,
               active_id, pending
    );

    modport slave (
        input  irq, pc, ibound, ei, di, rti, mask_wr, mask_in,
        output ienabled, istatus, intRA, take, vector,
               active_id, pending
    );

endinterface

// File: rtl/int_sched_irq_prio.sv
// Fixed-priority encoder: lowest set request bit wins.
module irq_prio
    import int_pkg::*;
#(
    parameter int NIRQ = 4,
    parameter int IDW  = id_w(NIRQ)
) (
    input  logic [NIRQ-1:0] req,
    output logic            any,
    output logic [IDW-1:0]  idx
);

    // Scan downward so the lowest index is the last to write idx.
    always_comb begin
        any = |req;
        idx = '0;
        for (int i = NIRQ - 1; i >= 0; i--) begin
            if (req[i]) idx = IDW'(i);
        end
    end

endmodule

// File: rtl/int_sched.sv
// Interrupt scheduler: edge capture, masked priority pick,
// entry at instruction boundaries and regfile context outputs.
module int_sched
    import int_pkg::*;
#(
    parameter int          NIRQ      = 4,
    parameter logic [15:0] VEC_BASE  = VEC_BASE_DEF,
    parameter int          VEC_SHIFT = VEC_SHIFT_DEF
) (
    input  logic       clk,
    input  logic       nclr,
    int_sched_if.slave bus
);

    localparam int IDW = id_w(NIRQ);

    logic [1:0]      state;
    logic [1:0]      state_nx;
    logic [NIRQ-1:0] irq_q;
    logic [NIRQ-1:0] pending;
    logic [NIRQ-1:0] mask;
    logic [NIRQ-1:0] cand;
    logic [NIRQ-1:0] rise;
    logic [NIRQ-1:0] clr;
    logic            any;
    logic [IDW-1:0]  win;
    logic            accept;
    logic            ien;
    logic            ien_nx;
    logic            in_svc;
    logic            take_q;
    logic [15:0]     ret_addr;
    logic [15:0]     ra_nx;
    logic [15:0]     vec;
    logic [15:0]     vec_nx;
    logic [IDW-1:0]  act_id;

    assign rise = bus.irq & ~irq_q;
    assign cand = pending & mask;

    irq_prio #(
        .NIRQ (NIRQ),
        .IDW  (IDW)
    ) u_prio (
        .req  (cand),
        .any  (any),
        .idx  (win)
    );

    // Old ienabled gates entry, so EI lags by one instruction.
    assign accept = (state == ST_RUN) && bus.ibound && ien && any;

    always_ff @(posedge clk or negedge nclr) begin
        if (!nclr) state <= ST_RUN;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_RUN:     if (accept) state_nx = ST_ENTER;
            ST_ENTER:   state_nx = ST_SERVICE;
            ST_SERVICE: if (bus.ibound && bus.rti) state_nx = ST_RUN;
            default:    state_nx = ST_RUN;
        endcase
    end

    always_comb begin
        clr = '0;
        if (accept) clr[win] = 1'b1;
        ien_nx = ien;
        if (bus.ibound &&
            (state == ST_RUN || state == ST_SERVICE)) begin
            if (bus.di)      ien_nx = 1'b0;
            else if (bus.ei) ien_nx = 1'b1;
        end
        ra_nx = ret_addr;
        if (state == ST_RUN && bus.ibound) ra_nx = bus.pc;
        vec_nx = VEC_BASE + (16'(win) << VEC_SHIFT);
    end

    always_ff @(posedge clk or negedge nclr) begin
        if (!nclr) begin
            irq_q    <= '0;
            pending  <= '0;
            mask     <= '0;
            ien      <= 1'b0;
            in_svc   <= 1'b0;
            take_q   <= 1'b0;
            ret_addr <= '0;
            vec      <= VEC_BASE;
            act_id   <= '0;
        end else begin
            irq_q    <= bus.irq;
            // A fresh edge beats a same-cycle clear of that bit.
            pending  <= (pending & ~clr) | rise;
            if (bus.mask_wr) mask <= bus.mask_in;
            ien      <= ien_nx;
            in_svc   <= (state_nx == ST_SERVICE);
            take_q   <= (state_nx == ST_ENTER);
            ret_addr <= ra_nx;
            if (accept) begin
                act_id <= win;
                vec    <= vec_nx;
            end
        end
    end

    assign bus.ienabled  = ien;
    assign bus.istatus   = in_svc;
    assign bus.intRA     = ret_addr;
    assign bus.take      = take_q;
    assign bus.vector    = vec;
    assign bus.active_id = act_id;
    assign bus.pending   = pending;

endmodule
